// File: rtl/spectrum_pingpong_buf.sv
// rtl/spectrum_pingpong_buf.sv - double-buffered spectrum frame store with peak-hold/average merge
//
// Two banks of DEPTH x DATA_W. The incoming magnitude stream fills the write bank
// (!disp_bank). Each written bin can be merged with the same bin of the displayed
// frame. Banks swap only at a frame boundary while the reader is unlocked.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   mode, hold_clr        merge select (0/3 raw, 1 peak, 2 average), raw-next-frame request
//   wr_valid/wr_ready     write handshake; wr_sof marks bin 0, wr_data is the magnitude
//   rd_lock               reader mid-frame, defers swap
//   rd_en/rd_addr         read request; rd_data/rd_valid one cycle later
//   frame_done, frame_cnt swap pulse and swap count
//   disp_bank             bank currently displayed
//   sync_err              wr_sof accepted away from bin 0
module spectrum_pingpong_buf #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              hold_clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_sof,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_lock,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              disp_bank,
    output logic              sync_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] tgt_addr;
    logic              swap_pend;
    logic              clr_pend;
    logic              frame_clr;
    logic [1:0]        frame_mode;
    logic [1:0]        eff_mode;

    // one-deep commit stage: sample accepted last cycle plus its merge operand
    logic              p_valid;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_data;
    logic [1:0]        p_mode;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] merged;
    logic [DATA_W:0]   sum;

    logic acc;
    logic bin0;
    logic last_bin;
    logic do_swap;

    assign wr_ready = !swap_pend;
    assign acc      = wr_valid & wr_ready;
    assign tgt_addr = wr_sof ? '0 : wr_addr;
    assign bin0     = (tgt_addr == '0);
    assign last_bin = (tgt_addr == '1);
    // swap_pend is only set by the accept of the last bin, so in its first cycle
    // the final write commits on the same edge that flips the banks.
    assign do_swap  = swap_pend & !rd_lock;

    // mode is latched at bin 0; a pending clear forces the whole frame raw
    always_comb begin
        eff_mode = frame_mode;
        if (bin0) begin
            eff_mode = clr_pend ? 2'd0 : mode;
        end
    end

    always_comb begin
        sum    = {1'b0, p_data} + {1'b0, old_q} + (DATA_W+1)'(1);
        merged = p_data;
        case (p_mode)
            2'd1:    merged = (p_data > old_q) ? p_data : old_q;
            2'd2:    merged = sum[DATA_W:1];
            default: merged = p_data;
        endcase
    end

    // storage: no reset on the arrays
    always_ff @(posedge clk) begin
        if (acc) begin
            old_q <= disp_bank ? mem1[tgt_addr] : mem0[tgt_addr];
        end
        if (p_valid && rst_n) begin
            if (disp_bank) begin
                mem0[p_addr] <= merged;
            end else begin
                mem1[p_addr] <= merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            disp_bank  <= 1'b0;
            swap_pend  <= 1'b0;
            clr_pend   <= 1'b1;
            frame_clr  <= 1'b0;
            frame_mode <= 2'd0;
            p_valid    <= 1'b0;
            p_addr     <= '0;
            p_data     <= '0;
            p_mode     <= 2'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            frame_cnt  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            p_valid    <= acc;
            rd_valid   <= rd_en;
            if (rd_en) begin
                rd_data <= disp_bank ? mem1[rd_addr] : mem0[rd_addr];
            end
            if (acc) begin
                p_addr  <= tgt_addr;
                p_data  <= wr_data;
                p_mode  <= eff_mode;
                wr_addr <= tgt_addr + 1'b1;
                if (bin0) begin
                    frame_mode <= eff_mode;
                    frame_clr  <= clr_pend;
                end
                if (wr_sof && (wr_addr != '0)) begin
                    sync_err <= 1'b1;
                end
                if (last_bin) begin
                    swap_pend <= 1'b1;
                end
            end
            if (do_swap) begin
                disp_bank  <= !disp_bank;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
                swap_pend  <= 1'b0;
            end
            // a new request always wins over retiring the current one
            if (hold_clr) begin
                clr_pend <= 1'b1;
            end else if (acc && last_bin && frame_clr) begin
                clr_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_pingpong_buf.sv
// tb/tb_spectrum_pingpong_buf.sv - scoreboard bench for spectrum_pingpong_buf
module tb_spectrum_pingpong_buf;

    localparam int DW = 11;
    localparam int AW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          hold_clr;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_sof;
    logic [DW-1:0] wr_data;
    logic          rd_lock;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;
    logic          disp_bank;
    logic          sync_err;

    always #5 clk = ~clk;

    spectrum_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .hold_clr(hold_clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sof(wr_sof), .wr_data(wr_data),
        .rd_lock(rd_lock), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .disp_bank(disp_bank), .sync_err(sync_err)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fv[16];
    logic [DW-1:0] ev[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every rd_valid pops one expected word
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid unexpected", 1, 0);
            end else begin
                chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    // called at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input logic [DW-1:0] d, input logic sof);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_sof   = sof;
        while (wr_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (wr_ready !== 1'b1) chk("wr_ready timeout", 0, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 16; i++) send(fv[i], i == 0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int k = 0; k < 16; k++) rd(AW'(k), ev[k]);
        @(negedge clk);
    endtask

    task automatic wait_swap(input int cnt, input int bank);
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done seen", int'(frame_done), 1);
        chk("frame_cnt", int'(frame_cnt), cnt);
        chk("disp_bank", int'(disp_bank), bank);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        hold_clr = 1'b1;
        @(negedge clk);
        hold_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mode = 2'd0; hold_clr = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0;
        wr_data = '0; rd_lock = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst wr_ready", int'(wr_ready), 1);
        chk("rst disp_bank", int'(disp_bank), 0);
        chk("rst frame_cnt", int'(frame_cnt), 0);
        chk("rst frame_done", int'(frame_done), 0);
        chk("rst rd_valid", int'(rd_valid), 0);
        chk("rst rd_data", int'(rd_data), 0);
        chk("rst sync_err", int'(sync_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ramp, raw, exact swap timing
        for (int k = 0; k < 16; k++) begin fv[k] = DW'(k); ev[k] = DW'(k); end
        send_frame();
        chk("t1 wr_ready low after last", int'(wr_ready), 0);
        chk("t1 no early frame_done", int'(frame_done), 0);
        @(negedge clk);
        chk("t1 frame_done", int'(frame_done), 1);
        chk("t1 disp_bank", int'(disp_bank), 1);
        chk("t1 frame_cnt", int'(frame_cnt), 1);
        @(negedge clk);
        chk("t1 wr_ready back", int'(wr_ready), 1);
        read_all();

        // peak hold, then clear
        mode = 2'd1;
        send_frame();
        wait_swap(2, 0);
        for (int k = 0; k < 16; k++) begin
            fv[k] = DW'(15 - k);
            ev[k] = DW'((k > 15 - k) ? k : 15 - k);
        end
        send_frame();
        wait_swap(3, 1);
        read_all();
        pulse_clr();
        for (int k = 0; k < 16; k++) begin fv[k] = DW'(3); ev[k] = DW'(3); end
        send_frame();
        wait_swap(4, 0);
        read_all();
        for (int k = 0; k < 16; k++) fv[k] = DW'(1);
        send_frame();
        wait_swap(5, 1);
        read_all();

        // average, including saturating operands
        mode = 2'd2;
        pulse_clr();
        for (int k = 0; k < 16; k++) fv[k] = (k < 8) ? DW'(2047) : DW'(5);
        send_frame();
        wait_swap(6, 0);
        for (int k = 0; k < 16; k++) begin
            fv[k] = (k < 4) ? DW'(0) : (k < 8) ? DW'(2047) : DW'(6);
            ev[k] = (k < 4) ? DW'(1024) : (k < 8) ? DW'(2047) : DW'(6);
        end
        send_frame();
        wait_swap(7, 1);
        read_all();

        // reader lock defers swap
        mode = 2'd0;
        rd_lock = 1'b1;
        for (int k = 0; k < 16; k++) begin fv[k] = DW'(100 + k); ev[k] = DW'(100 + k); end
        send_frame();
        begin
            int seen = 0;
            for (int c = 0; c < 10; c++) begin
                if (frame_done === 1'b1) seen++;
                @(negedge clk);
            end
            chk("t4 no swap while locked", seen, 0);
        end
        chk("t4 wr_ready held low", int'(wr_ready), 0);
        chk("t4 cnt held", int'(frame_cnt), 7);
        rd(AW'(0), DW'(1024));
        rd_lock = 1'b0;
        @(negedge clk);
        chk("t4 swap on release", int'(frame_done), 1);
        chk("t4 disp_bank", int'(disp_bank), 0);
        chk("t4 frame_cnt", int'(frame_cnt), 8);
        read_all();

        // misplaced start-of-frame
        for (int k = 0; k < 7; k++) send(DW'(200 + k), k == 0);
        send(DW'(50), 1'b1);
        chk("t5 sync_err", int'(sync_err), 1);
        for (int k = 1; k < 15; k++) send(DW'(50 + k), 1'b0);
        chk("t5 no swap for broken frame", int'(frame_cnt), 8);
        chk("t5 wr_ready before last", int'(wr_ready), 1);
        send(DW'(65), 1'b0);
        wait_swap(9, 1);
        for (int k = 0; k < 16; k++) ev[k] = DW'(50 + k);
        read_all();

        // reset mid-frame under peak-hold
        mode = 2'd1;
        for (int k = 0; k < 5; k++) send(DW'(9), k == 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6 rst frame_cnt", int'(frame_cnt), 0);
        chk("t6 rst disp_bank", int'(disp_bank), 0);
        chk("t6 rst wr_ready", int'(wr_ready), 1);
        chk("t6 rst rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin fv[k] = DW'(1); ev[k] = DW'(1); end
        send_frame();
        wait_swap(1, 1);
        read_all();

        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
